// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 one-hot decoder.
// Accepts 3-bit codes over valid/ready and drives the matching one-hot line
// for HOLD_CYCLES cycles, followed by GAP_CYCLES all-zero cycles. A one-entry
// pending buffer lets a second code queue while the current one is driven.
module decoder_3x8_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] code,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       done,
    output logic       busy
);

    // Counter reload values; the hold/gap counters count down to zero.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       y_q;
    logic [7:0]       y_d;
    logic             y_valid_q;
    logic             y_valid_d;
    logic             done_q;
    logic             done_d;
    logic             pend_full_q;
    logic             pend_full_d;
    logic [2:0]       pend_code_q;
    logic [2:0]       pend_code_d;

    logic             accept;
    logic             start;
    logic [2:0]       start_code;
    logic             take_code;
    logic             next_code;

    // Map a 3-bit code onto its one-hot output line.
    function automatic logic [7:0] decode_onehot(input logic [2:0] c);
        decode_onehot = 8'h01 << c;
    endfunction

    // Handshake: no accepts during reset, abort, or while the buffer is full.
    assign in_ready = rst_n && en && !pend_full_q && !clr;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE) || pend_full_q;

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign done     = done_q;

    // State, counter, output and pending-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            y_q         <= 8'h00;
            y_valid_q   <= 1'b0;
            done_q      <= 1'b0;
            pend_full_q <= 1'b0;
            pend_code_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            done_q      <= done_d;
            pend_full_q <= pend_full_d;
            pend_code_q <= pend_code_d;
        end
    end

    // Next-state, next-output and pending-buffer logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        done_d      = 1'b0;
        pend_full_d = pend_full_q;
        pend_code_d = pend_code_q;
        start       = 1'b0;
        start_code  = code;
        take_code   = 1'b0;
        next_code   = 1'b0;

        if (clr) begin
            // Abort everything; in_ready is low so nothing is accepted.
            state_d     = IDLE;
            cnt_d       = CNT_ZERO;
            y_d         = 8'h00;
            y_valid_d   = 1'b0;
            pend_full_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        start     = 1'b1;
                        take_code = 1'b1;
                    end else if (en && pend_full_q) begin
                        start       = 1'b1;
                        start_code  = pend_code_q;
                        pend_full_d = 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d  = cnt_q - CNT_ONE;
                        done_d = (cnt_q == CNT_ONE);
                    end else if (HAS_GAP) begin
                        state_d   = GAP;
                        cnt_d     = GAP_LOAD;
                        y_d       = 8'h00;
                        y_valid_d = 1'b0;
                    end else begin
                        next_code = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        next_code = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    y_d       = 8'h00;
                    y_valid_d = 1'b0;
                end
            endcase

            // End of a drive/gap sequence: pending code first, then bypass.
            if (next_code) begin
                if (en && pend_full_q) begin
                    start       = 1'b1;
                    start_code  = pend_code_q;
                    pend_full_d = 1'b0;
                end else if (en && accept) begin
                    start     = 1'b1;
                    take_code = 1'b1;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    y_d       = 8'h00;
                    y_valid_d = 1'b0;
                end
            end

            // Launch a new drive window.
            if (start) begin
                state_d   = DRIVE;
                cnt_d     = HOLD_LOAD;
                y_d       = decode_onehot(start_code);
                y_valid_d = 1'b1;
                done_d    = (HOLD_LOAD == CNT_ZERO);
            end

            // Accepted codes not consumed directly land in the pending buffer.
            if (accept && !take_code) begin
                pend_full_d = 1'b1;
                pend_code_d = code;
            end
        end
    end

endmodule
